regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
// - Shares the single register-file write port between the in-order pipeline writeback (A) and a
//   long-latency unit (B: load miss return / divider). Registered write port drives regfile directly.
// - A has priority; B writes queue in a small FIFO and drain in idle A cycles; starvation guard forces drain.
// - Provides a pending-write query so decode stalls on RAW/WAW against queued B writes.
// PARAMETERS
// - DEPTH         4   B FIFO entries; power of two, >= 2
// - STARVE_LIMIT  8   consecutive non-empty cycles without a B pop before A is blocked; >= 1
// PORTS
// - clk        in   1   clock
// - rst_n      in   1   synchronous active-low reset
// - a_valid    in   1   pipeline writeback request
// - a_ready    out  1   A accepted when a_valid & a_ready
// - a_rd       in   5   A destination register
// - a_data     in   32  A write data
// - b_valid    in   1   long-latency unit request
// - b_ready    out  1   = !fifo_full (state only, no combinational path from b_valid/pop)
// - b_rd       in   5   B destination register
// - b_data     in   32  B write data
// - q_addr1    in   5   pending query, source reg 1
// - q_addr2    in   5   pending query, source reg 2
// - q_pending  out  1   some queued/in-flight B write targets q_addr1 or q_addr2 (x0 never pending)
// - rf_we      out  1   to regfile write_enable (registered)
// - rf_addr    out  5   to regfile address3 (registered)
// - rf_wdata   out  32  to regfile write_data (registered)
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): FIFO flushed, starve counter=0, rf_we=0, rf_addr=0, rf_wdata=0.
//   Queued writes are discarded; reset mid-drain loses them silently. a_ready=1, b_ready=1 after reset.
// - Grant per cycle, exactly one of: A (a_valid & a_ready), B pop (fifo non-empty & !A grant), none.
// - a_ready = !force_b; force_b = (starve_cnt == STARVE_LIMIT) & fifo non-empty.
// - Starve counter: +1 each cycle FIFO non-empty and no pop; cleared on pop or FIFO empty; saturates.
// - Latency: A accepted at t -> rf_we=1 at t+1. B accepted at t -> earliest rf_we at t+2 (FIFO path).
// - Grant none -> rf_we=0 next cycle; rf_addr/rf_wdata hold last value.
// - rd==0 (either side): request accepted/popped normally, rf_we forced 0 for that cycle.
// - FIFO: push on b_valid & b_ready; pop on B grant; push and pop in same cycle allowed (count unchanged).
//   Full: b_ready=0, b_valid ignored. Pointers wrap modulo DEPTH. Order within B strictly FIFO.
// - No ordering between A and B: a queued B write may land after a later A write to the same rd;
//   decode must use q_pending to stall such hazards.
// - q_pending: combinational OR over valid FIFO entries (rd != 0) plus output stage while it holds a
//   B write with rf_we=1; cleared the cycle after that entry is written (regfile then returns new value).
// CONFIGURATION
// - WB_BYPASS_EN defined: if FIFO empty, no A grant, b_valid=1 at t -> B skips FIFO, rf_we=1 at t+1
//   (b_ready stays 1); q_pending covers the bypassed write while in output stage.
// - WB_BYPASS_EN undefined: every B write goes through FIFO; minimum B latency 2 cycles.
// TESTING
// - Reset then idle 3 cycles -> rf_we=0, rf_addr=0, rf_wdata=0, a_ready=1, b_ready=1, q_pending=0.
// - A rd=5 data=0xDEADBEEF at t, B idle -> t+1 rf_we=1 rf_addr=5 rf_wdata=0xDEADBEEF.
// - a_valid held, B pushes rd=7,8 -> queued; q_addr1=8 -> q_pending=1; after STARVE_LIMIT=8 cycles
//   a_ready=0, rd=7 written next cycle, counter clears; rd=8 forced after another 8 cycles.
// - B pushes 5 writes with A busy, DEPTH=4 -> b_ready=0 after 4th, 5th held; A idle -> drained in order.
// - A rd=0 data=0x1 and B rd=0 data=0x2 -> both accepted, rf_we stays 0, q_addr1=0 -> q_pending=0.
// - Reset asserted with 3 queued B writes -> next cycle FIFO empty, rf_we=0, no queued write emitted.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback (A) and a queued
// long-latency unit (B). Optional macro WB_BYPASS_EN lets B skip an empty FIFO when A is idle.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_pending,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [CW-1:0] starve_cnt;
    logic          out_is_b;

    logic fifo_empty;
    logic fifo_full;
    logic force_b;
    logic a_grant;
    logic pop;
    logic push;
    logic bypass;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(DEPTH));
    assign force_b    = (starve_cnt == CW'(STARVE_LIMIT)) && !fifo_empty;
    assign a_ready    = !force_b;
    assign b_ready    = !fifo_full;
    assign a_grant    = a_valid && a_ready;
    assign pop        = !fifo_empty && !a_grant;

`ifdef WB_BYPASS_EN
    assign bypass = fifo_empty && !a_grant && b_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = b_valid && b_ready && !bypass;

    // Pending hazard: any live FIFO entry, or a B write sitting in the output stage.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = rd_ptr;
        q_pending = out_is_b && rf_we && (rf_addr == q_addr1 || rf_addr == q_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((PW+1)'(i) < count && fifo_rd[idx] != 5'd0 &&
                (fifo_rd[idx] == q_addr1 || fifo_rd[idx] == q_addr2))
                q_pending = 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= b_rd;
            fifo_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_addr    <= 5'd0;
            rf_wdata   <= 32'd0;
            out_is_b   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);

            if (fifo_empty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;

            // x0 destinations still consume their grant but never assert the write enable.
            if (a_grant) begin
                rf_we    <= (a_rd != 5'd0);
                rf_addr  <= a_rd;
                rf_wdata <= a_data;
                out_is_b <= 1'b0;
            end else if (pop) begin
                rf_we    <= (fifo_rd[rd_ptr] != 5'd0);
                rf_addr  <= fifo_rd[rd_ptr];
                rf_wdata <= fifo_data[rd_ptr];
                out_is_b <= 1'b1;
            end else if (bypass) begin
                rf_we    <= (b_rd != 5'd0);
                rf_addr  <= b_rd;
                rf_wdata <= b_data;
                out_is_b <= 1'b1;
            end else begin
                rf_we    <= 1'b0;
                out_is_b <= 1'b0;
            end
        end
    end

endmodule
